noc_input_unit: RTL

- Per-port router input stage that feeds the crossbar: one instance per input port, PORT_N instances per router.
- Buffers incoming flits in a credit-flow-controlled FIFO and computes the XY route on each head flit.
- Presents the head flit to the crossbar together with a request and the target output port.
- Pops a flit on grant, holding the route from head to tail (wormhole switching).

---
 rtl/noc_pkg.sv | 44 ++++
 rtl/noc_input_unit_if.sv | 39 +++
 rtl/noc_fifo.sv | 51 +++++
 rtl/noc_input_unit.sv | 111 +++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router types: port indices, flit format, input-unit state
// encoding and the dimension-ordered (XY) route function.
package noc_pkg;

    localparam int PORT_N    = 5;
    localparam int PORT_W    = 3;
    localparam int COORD_W   = 4;
    localparam int PAYLOAD_W = 16;

    localparam logic [PORT_W-1:0] P_LOCAL = 3'd0;
    localparam logic [PORT_W-1:0] P_EAST  = 3'd1;
    localparam logic [PORT_W-1:0] P_WEST  = 3'd2;
    localparam logic [PORT_W-1:0] P_NORTH = 3'd3;
    localparam logic [PORT_W-1:0] P_SOUTH = 3'd4;

    typedef struct packed {
        logic                 vld;
        logic                 hd;
        logic                 tl;
        logic [COORD_W-1:0]   dst_x;
        logic [COORD_W-1:0]   dst_y;
        logic [PAYLOAD_W-1:0] payload;
    } router_i_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } iu_state_e;

    // X is fully resolved before Y, which keeps the mesh deadlock-free.
    function automatic logic [PORT_W-1:0] xy_route(
        input logic [COORD_W-1:0] dst_x,
        input logic [COORD_W-1:0] dst_y,
        input logic [COORD_W-1:0] cur_x,
        input logic [COORD_W-1:0] cur_y
    );
        if (dst_x > cur_x)      return P_EAST;
        else if (dst_x < cur_x) return P_WEST;
        else if (dst_y > cur_y) return P_NORTH;
        else if (dst_y < cur_y) return P_SOUTH;
        else                    return P_LOCAL;
    endfunction

endpackage

// File: rtl/noc_input_unit_if.sv
// Input-unit link bundle: upstream flit/credit plus crossbar request/grant.
// master = input unit side; ovf_o exists only with NOC_IU_OVF_CHK_EN.
interface noc_input_unit_if
    import noc_pkg::*;
();
    router_i_t          in_i;
    logic               credit_o;
    router_i_t          flit_o;
    logic               req_o;
    logic [PORT_W-1:0]  port_o;
    logic [PORT_N-1:0]  grt_i;
`ifdef NOC_IU_OVF_CHK_EN
    logic               ovf_o;
`endif

    modport master (
        input  in_i,
        input  grt_i,
        output credit_o,
        output flit_o,
        output req_o,
`ifdef NOC_IU_OVF_CHK_EN
        output ovf_o,
`endif
        output port_o
    );

    modport slave (
        output in_i,
        output grt_i,
        input  credit_o,
        input  flit_o,
        input  req_o,
`ifdef NOC_IU_OVF_CHK_EN
        input  ovf_o,
`endif
        input  port_o
    );
endinterface

// File: rtl/noc_fifo.sv
// Synchronous FIFO of DEPTH entries; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module noc_fifo
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = router_i_t,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  T            din_i,
    input  logic        pop_i,
    output T            dout_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);
    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          wr_en, rd_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/noc_input_unit.sv
// Router input port: credit-controlled flit FIFO, XY route on head flits,
// wormhole hold of the route until the tail pops. Option: NOC_IU_OVF_CHK_EN.
module noc_input_unit
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PORT_ID = 0,
    parameter int unsigned CUR_X   = 0,
    parameter int unsigned CUR_Y   = 0
) (
    input logic              clk,
    input logic              rst_n,
    noc_input_unit_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    if (PORT_ID >= PORT_N || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_err
        $error("noc_input_unit: bad PORT_ID or DEPTH");
    end

    iu_state_e         state_q, state_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic              credit_q;
    logic              req, pop, full, empty;
    logic [AW:0]       fifo_count;
    logic              unused_count;
    router_i_t         head;

    noc_fifo #(
        .DEPTH (DEPTH),
        .T     (router_i_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.in_i.vld),
        .din_i   (bus.in_i),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    assign unused_count = ^fifo_count;

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        req     = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (head.hd) begin
                        port_d  = xy_route(head.dst_x, head.dst_y,
                                           COORD_W'(CUR_X), COORD_W'(CUR_Y));
                        state_d = ACTIVE;
                    end else begin
                        // Orphan body flit: drain it so its credit returns upstream.
                        pop = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                req = !empty;
                if (req && bus.grt_i[port_q]) begin
                    pop = 1'b1;
                    if (head.tl) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            port_q   <= '0;
            credit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            credit_q <= pop;
        end
    end

    assign bus.req_o    = req;
    assign bus.port_o   = port_q;
    assign bus.credit_o = credit_q;
    assign bus.flit_o   = req ? head : '0;

`ifdef NOC_IU_OVF_CHK_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            ovf_q <= 1'b0;
        else if (bus.in_i.vld && full && !pop) ovf_q <= 1'b1;
    end

    assign bus.ovf_o = ovf_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.in_i.vld && full && !pop))
                else $error("noc_input_unit: write into full FIFO dropped");
            assert (!(state_q == ACTIVE && bus.grt_i[port_q] && !req))
                else $error("noc_input_unit: grant without request");
        end
    end
`endif
endmodule
